// File: rtl/vid_rd_sched.sv
// rtl/vid_rd_sched.sv - display frame-buffer burst read scheduler
// Re-arms on each sync leading edge, flushes the pixel FIFO and fetches one frame in bursts.
module vid_rd_sched #(
    parameter int H_ACTIVE    = 1280,
    parameter int V_ACTIVE    = 720,
    parameter int BURST_LEN   = 64,
    parameter int BASE_ADDR   = 0,
    parameter int LINE_STRIDE = 1280,
    parameter int FIFO_DEPTH  = 2048,
    parameter int VS_POL      = 1,
    parameter int ADDR_W      = 24,
    parameter int LEVEL_W     = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              vs_i,
    input  logic              de_i,
    input  logic [LEVEL_W-1:0] fifo_level_i,
    input  logic              fifo_empty_i,
    output logic              fifo_clr_o,
    output logic              rd_req_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [7:0]        rd_len_o,
    input  logic              rd_ack_i,
    input  logic              rd_done_i,
    output logic              frame_busy_o,
    output logic              underflow_o,
    output logic              frame_err_o
);

    localparam int   OFF_W  = $clog2(H_ACTIVE + 1);
    localparam int   LINE_W = $clog2(V_ACTIVE + 1);
    localparam logic VS_ACT = (VS_POL != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_CHECK,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                vs_q;
    logic [OFF_W-1:0]    offset_q, offset_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [ADDR_W-1:0]   line_base_q, line_base_d;
    logic                restart_pend_q, restart_pend_d;
    logic                rd_req_q, rd_req_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [7:0]          rd_len_q, rd_len_d;
    logic                frame_busy_q, frame_busy_d;
    logic                underflow_q, underflow_d;
    logic                frame_err_q, frame_err_d;

    logic                fs;
    logic [15:0]         remain;
    logic [7:0]          len_w;
    logic [LEVEL_W:0]    level_sum;
    logic                room;
    logic [15:0]         off_sum;
    logic                line_end;
    logic                last_line;

    assign fs        = (vs_q != VS_ACT) && (vs_i == VS_ACT);
    assign remain    = 16'(H_ACTIVE) - 16'(offset_q);
    assign len_w     = (remain < 16'(BURST_LEN)) ? remain[7:0] : 8'(BURST_LEN);
    // One extra bit so a nearly full FIFO plus a burst cannot wrap past the depth.
    assign level_sum = (LEVEL_W+1)'(fifo_level_i) + (LEVEL_W+1)'(len_w);
    assign room      = level_sum <= (LEVEL_W+1)'(FIFO_DEPTH);
    assign off_sum   = 16'(offset_q) + 16'(rd_len_q);
    assign line_end  = off_sum == 16'(H_ACTIVE);
    assign last_line = (16'(line_q) + 16'd1) == 16'(V_ACTIVE);

    always_comb begin
        state_d        = state_q;
        offset_d       = offset_q;
        line_d         = line_q;
        line_base_d    = line_base_q;
        restart_pend_d = restart_pend_q;
        rd_req_d       = rd_req_q;
        rd_addr_d      = rd_addr_q;
        rd_len_d       = rd_len_q;
        frame_busy_d   = frame_busy_q;
        underflow_d    = underflow_q;
        frame_err_d    = 1'b0;

        if (de_i && fifo_empty_i && (frame_busy_q || state_q == S_DONE)) begin
            underflow_d = 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (fs) begin
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                frame_busy_d   = 1'b1;
                underflow_d    = 1'b0;
                line_base_d    = ADDR_W'(BASE_ADDR);
                line_d         = '0;
                offset_d       = '0;
                restart_pend_d = 1'b0;
                state_d        = S_CHECK;
            end
            S_CHECK: begin
                if (fs) begin
                    frame_err_d = 1'b1;
                    state_d     = S_CLR;
                end else if (room) begin
                    rd_req_d  = 1'b1;
                    rd_addr_d = line_base_q + ADDR_W'(offset_q);
                    rd_len_d  = len_w;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                // An accepted burst must be drained before restarting, so ack beats sync.
                if (rd_ack_i) begin
                    rd_req_d = 1'b0;
                    state_d  = S_WAIT;
                    if (fs) begin
                        restart_pend_d = 1'b1;
                        frame_err_d    = 1'b1;
                    end
                end else if (fs) begin
                    rd_req_d    = 1'b0;
                    frame_err_d = 1'b1;
                    state_d     = S_CLR;
                end
            end
            S_WAIT: begin
                if (rd_done_i) begin
                    if (restart_pend_q || fs) begin
                        frame_err_d = fs;
                        state_d     = S_CLR;
                    end else if (line_end) begin
                        offset_d    = '0;
                        line_base_d = line_base_q + ADDR_W'(LINE_STRIDE);
                        line_d      = line_q + LINE_W'(1);
                        if (last_line) begin
                            frame_busy_d = 1'b0;
                            state_d      = S_DONE;
                        end else begin
                            state_d = S_CHECK;
                        end
                    end else begin
                        offset_d = OFF_W'(off_sum);
                        state_d  = S_CHECK;
                    end
                end else if (fs) begin
                    restart_pend_d = 1'b1;
                    frame_err_d    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            vs_q           <= 1'b0;
            offset_q       <= '0;
            line_q         <= '0;
            line_base_q    <= ADDR_W'(BASE_ADDR);
            restart_pend_q <= 1'b0;
            rd_req_q       <= 1'b0;
            rd_addr_q      <= '0;
            rd_len_q       <= '0;
            frame_busy_q   <= 1'b0;
            underflow_q    <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            vs_q           <= vs_i;
            offset_q       <= offset_d;
            line_q         <= line_d;
            line_base_q    <= line_base_d;
            restart_pend_q <= restart_pend_d;
            rd_req_q       <= rd_req_d;
            rd_addr_q      <= rd_addr_d;
            rd_len_q       <= rd_len_d;
            frame_busy_q   <= frame_busy_d;
            underflow_q    <= underflow_d;
            frame_err_q    <= frame_err_d;
        end
    end

    assign fifo_clr_o   = (state_q == S_CLR);
    assign rd_req_o     = rd_req_q;
    assign rd_addr_o    = rd_addr_q;
    assign rd_len_o     = rd_len_q;
    assign frame_busy_o = frame_busy_q;
    assign underflow_o  = underflow_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: doc/vid_rd_sched.md
Name: vid_rd_sched

Overview:
Display-side read scheduler for the frame buffer feeding the HDMI/DVI output path. It re-arms on every vertical sync from the timing generator and flushes the pixel FIFO. It then issues flow-controlled burst read requests covering V_ACTIVE lines of H_ACTIVE pixels to the memory controller. It also flags FIFO underflow seen during active video.

Parameters:
H_ACTIVE, 1280, pixels per active line (words; 1 word = 1 pixel)
V_ACTIVE, 720, active lines per frame
BURST_LEN, 64, maximum words per read burst (1..255)
BASE_ADDR, 0, word address of pixel (0,0)
LINE_STRIDE, 1280, word distance between consecutive line starts (>= H_ACTIVE)
FIFO_DEPTH, 2048, pixel FIFO capacity in words
VS_POL, 1, active level of vs (1 positive, 0 negative)
ADDR_W, 24, memory word address width
LEVEL_W, 12, width of fifo_level

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous active-high reset
vs  in  1  vertical sync from timing generator
de  in  1  display data enable from timing generator
fifo_level  in  LEVEL_W  words currently in pixel FIFO (write side)
fifo_empty  in  1  pixel FIFO empty (read side)
fifo_clr  out  1  one-cycle FIFO flush pulse
rd_req  out  1  burst request valid
rd_addr  out  ADDR_W  burst start word address
rd_len  out  8  burst length in words
rd_ack  in  1  controller accepted current request
rd_done  in  1  last word of accepted burst written to FIFO
frame_busy  out  1  high from flush until last burst done
underflow  out  1  sticky: de high while fifo_empty in current frame
frame_err  out  1  one-cycle pulse: frame restarted before all lines fetched

Behaviour:
- Reset: state IDLE. All outputs 0. Line count, burst offset and restart_pend 0. line_base = BASE_ADDR.
- Frame start event fs: vs registered once; fs = (vs_d != VS_POL) && (vs == VS_POL), i.e. leading edge of sync.
- IDLE: wait for fs -> CLR.
- CLR (1 cycle): fifo_clr = 1, frame_busy <= 1, underflow <= 0, line_base <= BASE_ADDR, line = 0, offset = 0 -> CHECK.
- CHECK: len = min(BURST_LEN, H_ACTIVE - offset). Go to REQ only when fifo_level + len <= FIFO_DEPTH (compare at LEVEL_W+1 bits); otherwise stay in CHECK.
- REQ: rd_req = 1. rd_addr = line_base + offset (mod 2^ADDR_W) and rd_len = len, both registered and stable while rd_req is high. On rd_ack: rd_req <= 0 same edge -> WAIT.
- WAIT: on rd_done advance: offset += len. If offset reaches H_ACTIVE: offset = 0, line_base += LINE_STRIDE, line += 1. Then if line == V_ACTIVE -> DONE, else -> CHECK.
- DONE: frame_busy <= 0; wait for fs -> CLR.
- One request outstanding at most; no new rd_req before rd_done of the previous burst.
- Last burst of each line is short when H_ACTIVE % BURST_LEN != 0 (e.g. 1280/64 gives 20 full bursts; 10/4 gives 4,4,2).
- fs in CHECK or REQ (not acked): drop rd_req immediately, pulse frame_err -> CLR next cycle.
- fs in WAIT: set restart_pend and pulse frame_err. Continue waiting for rd_done, then -> CLR (no address update).
- fs in DONE or IDLE: normal restart, no frame_err.
- fs coinciding with rd_ack in REQ: the ack wins -> WAIT with restart_pend set.
- fs coinciding with rd_done in WAIT: -> CLR, frame_err pulsed.
- underflow: set when de && fifo_empty while frame_busy or DONE. Held until the next CLR.
- rst asserted mid-burst: immediate return to reset values. The memory controller is reset by the same rst.

Test Plan:
- H_ACTIVE=10, V_ACTIVE=2, BURST_LEN=4, LINE_STRIDE=16, BASE_ADDR=0x100, FIFO level 0, ack/done 1 cycle after request -> fifo_clr pulse, then bursts (0x100,4) (0x104,4) (0x108,2) (0x110,4) (0x114,4) (0x118,2); frame_busy drops after the 6th rd_done; no 7th request.
- Hold rd_ack low 5 cycles -> rd_req, rd_addr and rd_len stay constant; exactly one request accepted.
- fifo_level = FIFO_DEPTH-3 with BURST_LEN=4 -> stays in CHECK with rd_req 0. Lower level to FIFO_DEPTH-4 -> request issued next cycle.
- vs edge while in WAIT (burst at 0x104 outstanding) -> frame_err pulse; no request until rd_done; then fifo_clr and restart at 0x100.
- VS_POL=0: vs held low for 5 lines -> exactly one restart at the falling edge; no retrigger while low.
- de=1 with fifo_empty=1 for 1 cycle mid-frame -> underflow=1 and stays 1 until the next fifo_clr; rst mid-burst -> all outputs 0 on the next cycle.
